// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin front end that shares a single radix-4 booth_mul between N_REQ
//   requesters. One request is captured at a time. Its operands are held on the
//   multiplier for MUL_LAT cycles, and the signed product is then returned to the
//   requester that issued it as a one-cycle response pulse.
//
//   Optional feature: define BOOTH_ARB_STATS_EN to add o_grant_cnt. This port
//   carries one 16-bit saturating grant counter per requester.
module booth_mul_arbiter #(
  parameter int WORD_LEN = 8,
  parameter int N_REQ    = 4,
  parameter int MUL_LAT  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_arst_n,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*WORD_LEN-1:0] i_req_multiplier,
  input  logic [N_REQ*WORD_LEN-1:0] i_req_multiplicand,
  output logic [N_REQ-1:0]          o_rsp_valid,
  output logic [2*WORD_LEN-1:0]     o_rsp_result,
  output logic [WORD_LEN-1:0]       o_mul_multiplier,
  output logic [WORD_LEN-1:0]       o_mul_multiplicand,
  input  logic [2*WORD_LEN-1:0]     i_mul_result,
  output logic                      o_busy
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       o_grant_cnt
`endif
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     rsp_id;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       idx;
  logic                any_valid;
  logic                grant_en;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_LEN-1:0] multiplier_q;
  logic [WORD_LEN-1:0] multiplicand_q;
  logic [2*WORD_LEN-1:0] result_q;

  // Advance a requester index by one, wrapping at N_REQ (N_REQ need not be a power of two)
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(N_REQ - 1)) begin
      return '0;
    end
    return v + ID_W'(1);
  endfunction

  // Round-robin search: the first valid requester at or after rr_ptr wins
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) begin
        idx = idx - (ID_W+1)'(N_REQ);
      end
      if (!any_valid && i_req_valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = idx[ID_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; a grant is only possible in IDLE or in the RESP cycle
  always_comb begin
    state_next  = state;
    grant_en    = 1'b0;
    o_req_ready = '0;
    o_rsp_valid = '0;
    o_busy      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          grant_en   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        o_busy = 1'b1;
        if (cnt == CNT_LAST) begin
          state_next = RESP;
        end
      end
      RESP: begin
        o_busy      = 1'b1;
        o_rsp_valid = ONE_HOT0 << rsp_id;
        if (any_valid) begin
          grant_en   = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (grant_en && i_arst_n) begin
      o_req_ready = ONE_HOT0 << winner;
    end
  end

  // Operand capture, round-robin pointer, latency counter and result register
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_ptr         <= '0;
      rsp_id         <= '0;
      cnt            <= '0;
      multiplier_q   <= '0;
      multiplicand_q <= '0;
      result_q       <= '0;
    end else begin
      if (grant_en) begin
        multiplier_q   <= i_req_multiplier[int'(winner)*WORD_LEN +: WORD_LEN];
        multiplicand_q <= i_req_multiplicand[int'(winner)*WORD_LEN +: WORD_LEN];
        rsp_id         <= winner;
        rr_ptr         <= wrap_inc(winner);
      end
      if (state == ISSUE) begin
        if (cnt == CNT_LAST) begin
          cnt      <= '0;
          result_q <= i_mul_result;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_mul_multiplier   = multiplier_q;
  assign o_mul_multiplicand = multiplicand_q;
  assign o_rsp_result       = result_q;

`ifdef BOOTH_ARB_STATS_EN
  logic [15:0] grant_cnt [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_stats
    // Count transfers granted to requester k, saturating at all-ones
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        grant_cnt[k] <= '0;
      end else if (grant_en && (winner == ID_W'(k)) && (grant_cnt[k] != 16'hFFFF)) begin
        grant_cnt[k] <= grant_cnt[k] + 16'd1;
      end
    end
    assign o_grant_cnt[k*16 +: 16] = grant_cnt[k];
  end
`endif

endmodule
